// File: rtl/mem_stage.sv
// mem_stage: sequencer between execute and the memory access unit.
// Accepts one instruction at a time, issues a held-stable request to the
// memory unit for loads/stores, waits for completion or a fault, then
// presents a result or trap to writeback. Non-memory ops bypass the unit.
// Optional build macro MEM_STAGE_PERF_EN adds four 32-bit perf counters.
module mem_stage #(
  parameter int RD_BITS    = 5,
  parameter int CAUSE_BITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_is_mem,
  input  logic                  in_is_write,
  input  logic                  in_is_unsigned,
  input  logic [1:0]            in_op,
  input  logic [31:0]           in_addr,
  input  logic [31:0]           in_wdata,
  input  logic [31:0]           in_alu_result,
  input  logic [RD_BITS-1:0]    in_rd,
  output logic                  mem_available,
  output logic                  mem_is_write,
  output logic                  mem_is_unsigned,
  output logic [1:0]            mem_op,
  output logic [31:0]           mem_addr,
  output logic [31:0]           mem_in,
  input  logic [31:0]           mem_out,
  input  logic                  mem_busy,
  input  logic                  mem_op_fault,
  input  logic                  mem_addr_fault,
  input  logic                  mem_access_fault,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_data,
  output logic [RD_BITS-1:0]    out_rd,
  output logic                  out_wb_en,
  output logic                  out_trap,
  output logic [CAUSE_BITS-1:0] out_trap_cause,
  output logic [31:0]           out_trap_value
`ifdef MEM_STAGE_PERF_EN
  ,
  output logic [31:0]           perf_loads,
  output logic [31:0]           perf_stores,
  output logic [31:0]           perf_stall_cycles,
  output logic [31:0]           perf_traps
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t r_state;

  // Latched request fields; the memory unit only ever sees these.
  logic                  r_mem_available;
  logic                  r_is_write;
  logic                  r_is_unsigned;
  logic [1:0]            r_op;
  logic [31:0]           r_addr;
  logic [31:0]           r_wdata;
  logic [RD_BITS-1:0]    r_rd;

  // Registered writeback-side outputs.
  logic                  r_out_valid;
  logic [31:0]           r_out_data;
  logic [RD_BITS-1:0]    r_out_rd;
  logic                  r_out_wb_en;
  logic                  r_out_trap;
  logic [CAUSE_BITS-1:0] r_out_trap_cause;
  logic [31:0]           r_out_trap_value;

  logic                  w_fault;
  logic [CAUSE_BITS-1:0] w_cause;

  // Fault detection and cause encoding in priority order: op, alignment, access.
  always_comb begin
    w_fault = mem_op_fault | mem_addr_fault | mem_access_fault;
    w_cause = CAUSE_BITS'(2);
    if (mem_op_fault)
      w_cause = CAUSE_BITS'(2);
    else if (mem_addr_fault)
      w_cause = r_is_write ? CAUSE_BITS'(6) : CAUSE_BITS'(4);
    else if (mem_access_fault)
      w_cause = r_is_write ? CAUSE_BITS'(7) : CAUSE_BITS'(5);
  end

  // Main sequencer: state, latched request and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= S_IDLE;
      r_mem_available  <= 1'b0;
      r_is_write       <= 1'b0;
      r_is_unsigned    <= 1'b0;
      r_op             <= 2'b00;
      r_addr           <= 32'd0;
      r_wdata          <= 32'd0;
      r_rd             <= '0;
      r_out_valid      <= 1'b0;
      r_out_data       <= 32'd0;
      r_out_rd         <= '0;
      r_out_wb_en      <= 1'b0;
      r_out_trap       <= 1'b0;
      r_out_trap_cause <= '0;
      r_out_trap_value <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            if (!in_is_mem) begin
              // Pass-through: result is ready on the very next cycle.
              r_out_data  <= in_alu_result;
              r_out_rd    <= in_rd;
              r_out_wb_en <= 1'b1;
              r_out_trap  <= 1'b0;
              r_out_valid <= 1'b1;
              r_state     <= S_RESP;
            end else begin
              r_is_write      <= in_is_write;
              r_is_unsigned   <= in_is_unsigned;
              r_op            <= in_op;
              r_addr          <= in_addr;
              r_wdata         <= in_wdata;
              r_rd            <= in_rd;
              r_mem_available <= 1'b1;
              r_state         <= S_REQ;
            end
          end
        end
        S_REQ: begin
          // The unit's status outputs are not meaningful until the next cycle.
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (w_fault) begin
            r_out_trap       <= 1'b1;
            r_out_trap_cause <= w_cause;
            r_out_trap_value <= r_addr;
            r_out_wb_en      <= 1'b0;
            r_out_rd         <= '0;
            r_out_data       <= 32'd0;
            r_out_valid      <= 1'b1;
            r_mem_available  <= 1'b0;
            r_state          <= S_RESP;
          end else if (!mem_busy) begin
            r_out_trap <= 1'b0;
            if (r_is_write) begin
              r_out_data  <= 32'd0;
              r_out_rd    <= '0;
              r_out_wb_en <= 1'b0;
            end else begin
              r_out_data  <= mem_out;
              r_out_rd    <= r_rd;
              r_out_wb_en <= 1'b1;
            end
            r_out_valid     <= 1'b1;
            r_mem_available <= 1'b0;
            r_state         <= S_RESP;
          end
        end
        S_RESP: begin
          // At least one cycle here lets the unit see available=0 before the next request.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_out_trap  <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready        = (r_state == S_IDLE);
  assign mem_available   = r_mem_available;
  assign mem_is_write    = r_is_write;
  assign mem_is_unsigned = r_is_unsigned;
  assign mem_op          = r_op;
  assign mem_addr        = r_addr;
  assign mem_in          = r_wdata;
  assign out_valid       = r_out_valid;
  assign out_data        = r_out_data;
  assign out_rd          = r_out_rd;
  assign out_wb_en       = r_out_wb_en;
  assign out_trap        = r_out_trap;
  assign out_trap_cause  = r_out_trap_cause;
  assign out_trap_value  = r_out_trap_value;

`ifdef MEM_STAGE_PERF_EN
  logic [31:0] r_perf_loads;
  logic [31:0] r_perf_stores;
  logic [31:0] r_perf_stall_cycles;
  logic [31:0] r_perf_traps;

  // Wrapping event counters observed from the WAIT state decisions.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_loads        <= 32'd0;
      r_perf_stores       <= 32'd0;
      r_perf_stall_cycles <= 32'd0;
      r_perf_traps        <= 32'd0;
    end else if (r_state == S_WAIT) begin
      if (w_fault)
        r_perf_traps <= r_perf_traps + 32'd1;
      else if (!mem_busy) begin
        if (r_is_write)
          r_perf_stores <= r_perf_stores + 32'd1;
        else
          r_perf_loads <= r_perf_loads + 32'd1;
      end else
        r_perf_stall_cycles <= r_perf_stall_cycles + 32'd1;
    end
  end

  assign perf_loads        = r_perf_loads;
  assign perf_stores       = r_perf_stores;
  assign perf_stall_cycles = r_perf_stall_cycles;
  assign perf_traps        = r_perf_traps;
`endif

endmodule
